// File: rtl/hdmi_clk_switch_seq_pkg.sv
// Shared definitions for the HDMI pixel-clock switch sequencer:
// FSM state encoding, HDMI target resolution codes and the desired-select rule.
package hdmi_clk_switch_seq_pkg;

  // Raw encoding is exported on the debug status port, so values are fixed.
  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_HOLD     = 3'd2,
    ST_SWITCH   = 3'd3,
    ST_SETTLE   = 3'd4,
    ST_WAIT_CFG = 3'd5,
    ST_RELEASE  = 3'd6
  } clksw_state_e;

  // HDMI target resolution codes (video-timings encoding)
  localparam logic [2:0] HDMI_TARGET_480P  = 3'd0;
  localparam logic [2:0] HDMI_TARGET_720P  = 3'd1;
  localparam logic [2:0] HDMI_TARGET_960P  = 3'd2;
  localparam logic [2:0] HDMI_TARGET_1080P = 3'd3;
  localparam logic [2:0] HDMI_TARGET_1200P = 3'd4;

  // Desired mux select: 1 = HDMI_CLKsub, 0 = HDMI_CLKmain
  function automatic logic desired_sel(input logic       low_latency,
                                       input logic       n64_interlaced,
                                       input logic       vga_for_480p,
                                       input logic [2:0] target);
    logic sel;
    if (low_latency)
      sel = n64_interlaced;
    else if (target == HDMI_TARGET_480P)
      sel = vga_for_480p;
    else
      sel = (target == HDMI_TARGET_960P) || (target == HDMI_TARGET_1200P);
    return sel;
  endfunction

endpackage

// File: rtl/hdmi_clk_switch_seq_sel_debounce.sv
// Debouncer for the desired clock select: registers the request and reports
// when it has been unchanged for DEBOUNCE_CYCLES consecutive cycles.
module hdmi_clk_switch_seq_sel_debounce #(
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic srst_n,
  input  logic sel_d,
  output logic sel_q,
  output logic sel_stable
);

  localparam logic [CNT_W-1:0] STAB_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] stab_cnt_reg;

  // Sample the request and count how long it has matched the previous sample
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      sel_q        <= 1'b0;
      stab_cnt_reg <= '0;
    end else begin
      sel_q <= sel_d;
      if (sel_d != sel_q)
        stab_cnt_reg <= '0;
      else if (stab_cnt_reg != STAB_MAX)
        stab_cnt_reg <= stab_cnt_reg + CNT_W'(1);
    end
  end

  assign sel_stable = (stab_cnt_reg == STAB_MAX);

endmodule

// File: rtl/hdmi_clk_switch_seq.sv
// HDMI pixel-clock source switch sequencer (system clock domain).
// On a debounced change of the desired source: hold HDMI reset, switch the
// mux, let it settle, wait for the Si clock generator, then release.
// Optional build macro HDMI_CLKSW_STATUS_EN adds switch_cnt_o / state_o.
module hdmi_clk_switch_seq
  import hdmi_clk_switch_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int PRE_CYCLES      = 64,
  parameter int POST_CYCLES     = 256,
  parameter int CFG_TIMEOUT     = 1048575,
  parameter int CNT_W           = 20
) (
  input  logic       SYS_CLK_i,
  input  logic       nSRST_i,
  input  logic       lowlatencymode,
  input  logic       N64_interlaced,
  input  logic       use_vga_for_480p,
  input  logic [2:0] target_resolution,
  input  logic       Si_cfg_done_i,
  output logic       HDMI_CLK_sel_o,
  output logic       HDMI_hold_nRST_o,
  output logic       busy_o,
  output logic       cfg_timeout_o
`ifdef HDMI_CLKSW_STATUS_EN
  ,
  output logic [7:0] switch_cnt_o,
  output logic [2:0] state_o
`endif
);

  // Terminal counts: a state lasting N cycles leaves when cnt == N-1
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CFG_LAST  = CNT_W'(CFG_TIMEOUT - 1);

  clksw_state_e     state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             sel_reg, sel_next;
  logic             hold_n_reg, hold_n_next;
  logic             timeout_reg, timeout_next;
  logic             si_prev_reg;
  logic             si_fall;
  logic             sel_d, sel_q, sel_stable;

  assign sel_d   = desired_sel(lowlatencymode, N64_interlaced, use_vga_for_480p,
                               target_resolution);
  assign si_fall = si_prev_reg && !Si_cfg_done_i;

  hdmi_clk_switch_seq_sel_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_sel_debounce (
    .clk       (SYS_CLK_i),
    .srst_n    (nSRST_i),
    .sel_d     (sel_d),
    .sel_q     (sel_q),
    .sel_stable(sel_stable)
  );

  // State, counter and registered outputs
  always_ff @(posedge SYS_CLK_i) begin
    if (!nSRST_i) begin
      state_reg   <= ST_INIT;
      cnt_reg     <= '0;
      sel_reg     <= 1'b0;
      hold_n_reg  <= 1'b0;
      timeout_reg <= 1'b0;
      si_prev_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      sel_reg     <= sel_next;
      hold_n_reg  <= hold_n_next;
      timeout_reg <= timeout_next;
      si_prev_reg <= Si_cfg_done_i;
    end
  end

  // Next-state logic; the mux select only moves on the way out of INIT or
  // into SWITCH, both of which happen with the HDMI domain held in reset.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg + CNT_W'(1);
    sel_next     = sel_reg;
    timeout_next = timeout_reg;
    case (state_reg)
      ST_INIT: begin
        sel_next   = sel_d;
        state_next = ST_SETTLE;
      end
      ST_IDLE: begin
        // A stable select change wins; its sequence also waits for the Si.
        if (sel_stable && (sel_q != sel_reg))
          state_next = ST_HOLD;
        else if (si_fall)
          state_next = ST_WAIT_CFG;
      end
      ST_HOLD: begin
        if (cnt_reg == PRE_LAST) begin
          state_next = ST_SWITCH;
          sel_next   = sel_q;
        end
      end
      ST_SWITCH: state_next = ST_SETTLE;
      ST_SETTLE: begin
        if (cnt_reg == POST_LAST)
          state_next = ST_WAIT_CFG;
      end
      ST_WAIT_CFG: begin
        if (Si_cfg_done_i) begin
          timeout_next = 1'b0;
          state_next   = ST_RELEASE;
        end else if (cnt_reg == CFG_LAST) begin
          timeout_next = 1'b1;
          state_next   = ST_RELEASE;
        end
      end
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_INIT;
    endcase
    if ((state_next != state_reg) || (state_reg == ST_IDLE))
      cnt_next = '0;
    // Reset is released exactly when IDLE is (re)entered
    hold_n_next = (state_next == ST_IDLE);
  end

  assign HDMI_CLK_sel_o   = sel_reg;
  assign HDMI_hold_nRST_o = hold_n_reg;
  assign busy_o           = (state_reg != ST_IDLE);
  assign cfg_timeout_o    = timeout_reg;

`ifdef HDMI_CLKSW_STATUS_EN
  logic [7:0] switch_cnt_reg;

  // Saturating count of SWITCH entries for the debug register
  always_ff @(posedge SYS_CLK_i) begin
    if (!nSRST_i)
      switch_cnt_reg <= 8'd0;
    else if ((state_next == ST_SWITCH) && (state_reg != ST_SWITCH) &&
             (switch_cnt_reg != 8'hFF))
      switch_cnt_reg <= switch_cnt_reg + 8'd1;
  end

  assign switch_cnt_o = switch_cnt_reg;
  assign state_o      = state_reg;
`endif

endmodule
